// File: rtl/ppct_pkg.sv
// Shared definitions for the PPCT datapath: accumulator states, default widths
// and the per-THETA truncation-compensation biases used by RTL and benches alike.
package ppct_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Plain-constant encodings of state_e for RTL that keeps its state in logic.
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int PW_DEF      = 16;
    localparam int VEC_LEN_DEF = 8;

    // Expected value of the dropped partial-product columns for THETA = 0..8,
    // floor((THETA-1) * 2^(THETA-2)), i.e. the mean truncation error of the 8x8 array.
    localparam logic [15:0] COMP_BIAS_TBL [0:8] = '{
        16'd0, 16'd0, 16'd1, 16'd4, 16'd12, 16'd32, 16'd80, 16'd192, 16'd448
    };

endpackage

// File: rtl/ppct_len_counter.sv
// Vector length counter: counts accepted products and flags the beat that
// closes the vector, either on p_last or on reaching VEC_LEN.
module ppct_len_counter #(
    parameter int VEC_LEN = 8,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             last,
    output logic [CNT_W-1:0] cnt,
    output logic             close
);

    assign close = last || (cnt == CNT_W'(VEC_LEN - 1));

    // NOTE: non-blocking update, so close in this cycle is always derived from the pre-edge count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= close ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ppct_dot_acc.sv
// Streaming dot-product accumulator behind the column-truncated multiplier:
// sums biased products per vector and offers the result on a valid/ready port.
module ppct_dot_acc
    import ppct_pkg::*;
#(
    parameter int            PW        = PW_DEF,
    parameter int            VEC_LEN   = VEC_LEN_DEF,
    parameter int            CNT_W     = $clog2(VEC_LEN + 1),
    parameter int            ACC_W     = PW + CNT_W + 1,
    parameter logic [PW-1:0] COMP_BIAS = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [PW-1:0]    p_data,
    input  logic             p_last,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [ACC_W-1:0] s_data,
    output logic [CNT_W-1:0] s_len
);

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             close;
    logic             accept;

    // In HOLD a new product is only taken when the pending result leaves in the same cycle.
    assign p_ready = (state == ST_ACCUM) || s_ready;
    assign s_valid = (state == ST_HOLD);
    assign accept  = p_valid && p_ready;

    assign term = ACC_W'(p_data) + ACC_W'(COMP_BIAS);
    assign sum  = acc + term;

    ppct_len_counter #(
        .VEC_LEN (VEC_LEN),
        .CNT_W   (CNT_W)
    ) u_len (
        .clk   (clk),
        .rst   (rst),
        .step  (accept),
        .last  (p_last),
        .cnt   (cnt),
        .close (close)
    );

    // acc and cnt are already zero whenever a result is held, so a back-to-back
    // beat in HOLD is the same update as the first beat of a vector in ACCUM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_ACCUM;
            acc    <= '0;
            s_data <= '0;
            s_len  <= '0;
        end else if (accept && close) begin
            s_data <= sum;
            s_len  <= cnt + CNT_W'(1);
            acc    <= '0;
            state  <= ST_HOLD;
        end else begin
            if (accept) begin
                acc <= sum;
            end
            if ((state == ST_HOLD) && s_ready) begin
                state <= ST_ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_ppct_dot_acc.sv
// Scoreboard bench for ppct_dot_acc: one unbiased and one COMP_BIAS=3 instance
// share the stimulus; a monitor pops expected results whenever an output is accepted.
module tb_ppct_dot_acc;
    import ppct_pkg::*;

    localparam int ACC_W = 21;
    localparam int CNT_W = 4;
    localparam int BIAS1 = 3;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] len;
    } exp_t;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             p_valid = 1'b0;
    logic             p_last  = 1'b0;
    logic [15:0]      p_data  = '0;
    logic             s_ready = 1'b1;

    logic             p_ready0, s_valid0, p_ready1, s_valid1;
    logic [ACC_W-1:0] s_data0, s_data1;
    logic [CNT_W-1:0] s_len0, s_len1;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;
    int pushes   = 0;
    int pops     = 0;
    int cyc      = 0;

    logic                   hold0 = 1'b0, hold1 = 1'b0;
    logic [ACC_W+CNT_W-1:0] hold_val0 = '0, hold_val1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppct_dot_acc dut0 (
        .clk     (clk),
        .rst     (rst),
        .p_valid (p_valid),
        .p_ready (p_ready0),
        .p_data  (p_data),
        .p_last  (p_last),
        .s_valid (s_valid0),
        .s_ready (s_ready),
        .s_data  (s_data0),
        .s_len   (s_len0)
    );

    ppct_dot_acc #(.COMP_BIAS(16'(BIAS1))) dut1 (
        .clk     (clk),
        .rst     (rst),
        .p_valid (p_valid),
        .p_ready (p_ready1),
        .p_data  (p_data),
        .p_last  (p_last),
        .s_valid (s_valid1),
        .s_ready (s_ready),
        .s_data  (s_data1),
        .s_len   (s_len1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // The biased instance adds BIAS1 once per product.
    task automatic push_exp(input logic [ACC_W-1:0] sum, input logic [CNT_W-1:0] len);
        exp_t e;
        e.data = sum;
        e.len  = len;
        q0.push_back(e);
        e.data = sum + ACC_W'(len) * ACC_W'(BIAS1);
        q1.push_back(e);
        pushes++;
    endtask

    task automatic pop_cmp(input int which, input logic [ACC_W-1:0] d, input logic [CNT_W-1:0] l);
        exp_t e;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_result%0d", which), 64'(d), 64'hDEAD);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("s_data%0d", which), 64'(d), 64'(e.data));
            check($sformatf("s_len%0d", which), 64'(l), 64'(e.len));
            pops++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid0 && s_ready) pop_cmp(0, s_data0, s_len0);
            if (s_valid1 && s_ready) pop_cmp(1, s_data1, s_len1);
            if (hold0) check("hold_stable0", 64'({s_len0, s_data0}), 64'(hold_val0));
            if (hold1) check("hold_stable1", 64'({s_len1, s_data1}), 64'(hold_val1));
        end
        hold0     = s_valid0 && !s_ready;
        hold1     = s_valid1 && !s_ready;
        hold_val0 = {s_len0, s_data0};
        hold_val1 = {s_len1, s_data1};
    end

    // Presents one product and returns just after the edge that accepts it.
    task automatic beat(input logic [15:0] d, input logic l);
        int waited = 0;
        p_valid = 1'b1;
        p_data  = d;
        p_last  = l;
        @(negedge clk);
        while (!p_ready0) begin
            waited++;
            if (waited > 20) begin
                check("beat_accept_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
        end
        if (waited != 0) stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        p_valid = 1'b0;
        p_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_valid0", 64'(s_valid0), 64'd0);
        check("rst_s_valid1", 64'(s_valid1), 64'd0);
        check("rst_s_data0", 64'(s_data0), 64'd0);
        check("rst_s_len0", 64'(s_len0), 64'd0);
        check("rst_p_ready0", 64'(p_ready0), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full-length vector closed by the length limit.
        push_exp(21'h00800, 4'd8);
        for (int i = 0; i < 8; i++) beat(16'h0100, 1'b0);
        idle(2);

        // Early close on p_last; p_last without p_valid must be ignored.
        push_exp(21'd21, 4'd3);
        beat(16'd5, 1'b0);
        p_valid = 1'b0;
        p_last  = 1'b1;
        @(posedge clk);
        #1;
        beat(16'd7, 1'b0);
        beat(16'd9, 1'b1);
        push_exp(21'd4, 4'd1);
        beat(16'd4, 1'b1);
        idle(2);

        // Maximum products with a redundant p_last on beat 8.
        push_exp(21'h7FFF8, 4'd8);
        for (int i = 0; i < 8; i++) beat(16'hFFFF, i == 7);
        idle(2);

        // Back-to-back vectors with no bubble.
        push_exp(21'd8, 4'd8);
        push_exp(21'd8, 4'd8);
        stalls = 0;
        c0 = cyc;
        for (int i = 0; i < 16; i++) beat(16'd1, 1'b0);
        check("b2b_cycles", 64'(cyc - c0), 64'd16);
        check("b2b_stalls", 64'(stalls), 64'd0);
        idle(2);

        // Backpressure on a pending result, then release with a new beat.
        s_ready = 1'b0;
        push_exp(21'd6, 4'd3);
        beat(16'd2, 1'b0);
        beat(16'd2, 1'b0);
        beat(16'd2, 1'b1);
        p_valid = 1'b0;
        p_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_p_ready0", 64'(p_ready0), 64'd0);
            check("bp_s_valid0", 64'(s_valid0), 64'd1);
            check("bp_s_data0", 64'(s_data0), 64'd6);
        end
        @(posedge clk);
        #1;
        s_ready = 1'b1;
        push_exp(21'd10, 4'd2);
        stalls = 0;
        beat(16'd5, 1'b0);
        beat(16'd5, 1'b1);
        check("release_stalls", 64'(stalls), 64'd0);
        idle(2);

        // Reset drops a pending result, then a partial vector.
        s_ready = 1'b0;
        beat(16'd7, 1'b1);
        p_valid = 1'b0;
        p_last  = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_drop_s_valid0", 64'(s_valid0), 64'd0);
        check("rst_drop_s_valid1", 64'(s_valid1), 64'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(16'd10, 1'b0);
        p_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_p_ready0", 64'(p_ready0), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(21'd8, 4'd8);
        for (int i = 0; i < 8; i++) beat(16'd1, 1'b0);
        idle(2);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_q0", 64'(q0.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);
        check("result_count", 64'(pops), 64'(2 * pushes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
